// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: iterative shift-add multiply and restoring divide,
// W steps per operation, with directly writable HI/LO registers.
module hilo_muldiv #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         abort,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wHi,
    input  logic [W-1:0] wLo,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rHi,
    output logic [W-1:0] rLo
);

    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state;
    logic             divOp;
    logic             negA;
    logic             negB;
    logic             bZero;
    logic [W-1:0]     dMag;
    logic [W-1:0]     acc;
    logic [W-1:0]     mq;
    logic [CNT_W-1:0] cnt;

    logic [W:0]       addSum;
    logic [W:0]       shifted;
    logic [W:0]       trial;
    logic [W-1:0]     accNext;
    logic [W-1:0]     mqNext;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     hiRes;
    logic [W-1:0]     loRes;

    function automatic logic [W-1:0] condNeg(input logic signed [W-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*W-1:0] condNeg2(input logic signed [2*W-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    // One iteration: multiply shifts {acc,mq} right after a conditional add;
    // divide shifts the next dividend bit into acc and keeps the trial difference if non-negative.
    always_comb begin
        addSum  = {1'b0, acc} + (mq[0] ? {1'b0, dMag} : '0);
        shifted = {acc, mq[W-1]};
        trial   = shifted - {1'b0, dMag};
        if (divOp) begin
            if (!trial[W]) begin
                accNext = trial[W-1:0];
                mqNext  = {mq[W-2:0], 1'b1};
            end else begin
                accNext = shifted[W-1:0];
                mqNext  = {mq[W-2:0], 1'b0};
            end
        end else begin
            accNext = addSum[W:1];
            mqNext  = {addSum[0], mq[W-1:1]};
        end
    end

    // Sign correction of the magnitude result; divide-by-zero forces LO to all ones
    // while HI recovers the original dividend.
    always_comb begin
        prod = condNeg2({acc, mq}, negA ^ negB);
        if (divOp) begin
            hiRes = condNeg(acc, negA);
            loRes = bZero ? '1 : condNeg(mq, negA ^ negB);
        end else begin
            hiRes = prod[2*W-1:W];
            loRes = prod[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rHi   <= '0;
            rLo   <= '0;
            divOp <= 1'b0;
            negA  <= 1'b0;
            negB  <= 1'b0;
            bZero <= 1'b0;
            dMag  <= '0;
            acc   <= '0;
            mq    <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (hi_we) rHi <= wHi;
            if (lo_we) rLo <= wLo;
            case (state)
                IDLE: begin
                    if (start) begin
                        divOp <= op[1];
                        negA  <= op[0] & a[W-1];
                        negB  <= op[0] & b[W-1];
                        bZero <= (b == '0);
                        mq    <= condNeg(a, op[0] & a[W-1]);
                        dMag  <= condNeg(b, op[0] & b[W-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= accNext;
                        mq  <= mqNext;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(W - 1)) state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    // Result writeback overrides any direct write on this edge.
                    if (!abort) begin
                        rHi  <= hiRes;
                        rLo  <= loRes;
                        done <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected HI/LO and completion cycle are queued
// at issue time and checked by a monitor on every done pulse.
module tb_hilo_muldiv;

    localparam int W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wHi = '0, wLo = '0;
    logic        busy, done;
    logic [31:0] rHi, rLo;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  rHi8, rLo8;

    exp_t q[$];
    exp_t q8[$];
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatch = 0;

    hilo_muldiv #(.W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .hi_we(hi_we), .lo_we(lo_we), .wHi(wHi), .wLo(wLo),
        .busy(busy), .done(done), .rHi(rHi), .rLo(rLo)
    );

    hilo_muldiv #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(2'b00), .a(a8), .b(b8), .abort(1'b0),
        .hi_we(1'b0), .lo_we(1'b0), .wHi(8'h00), .wLo(8'h00),
        .busy(busy8), .done(done8), .rHi(rHi8), .rLo(rLo8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatch++;
            $display("FAIL %s: got %08h required %08h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("FAIL unexpectedDone: got done=1 required done=0 at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                check("resultHi", rHi, e.hi);
                check("resultLo", rLo, e.lo);
                check("doneCycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("FAIL unexpectedDone8: got done=1 required done=0 at cycle %0d", cyc);
            end else begin
                e = q8.pop_front();
                check("resultHi8", 32'(rHi8), e.hi);
                check("resultLo8", 32'(rLo8), e.lo);
                check("doneCycle8", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drive at a negedge; start is sampled on the following rising edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input bit withAbort);
        op = o; a = x; b = y; start = 1'b1; abort = withAbort;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        if (push) q.push_back('{eh, el, cyc + W + 1});
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((q.size() != 0 || q8.size() != 0 || busy || busy8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            nCompared++;
            nMismatch++;
            $display("FAIL idleTimeout: got pending=%0d required pending=0", q.size() + q8.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got running required finished");
        $fatal(1);
    end

    initial begin
        int nb;
        #3;
        check("resetHi", rHi, 32'h0);
        check("resetLo", rLo, 32'h0);
        check("resetBusy", 32'(busy), 32'h0);
        check("resetDone", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // First start right after reset release, with busy-duration measurement.
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0);
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            @(posedge clk);
            #1;
        end
        check("busyCycles", 32'(nb), 32'(W + 1));
        waitIdle();

        // MULT with an ignored start pulse mid-operation.
        issue(2'b01, 32'hFFFFFFFD, 32'h00000005, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        repeat (5) @(posedge clk);
        #1;
        op = 2'b00; a = 32'h1; b = 32'h1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();

        issue(2'b11, 32'hFFFFFFF9, 32'h00000002, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        waitIdle();
        issue(2'b10, 32'h00000007, 32'h00000000, 1, 32'h00000007, 32'hFFFFFFFF, 0);
        waitIdle();
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0);
        waitIdle();
        issue(2'b11, 32'h00000007, 32'hFFFFFFFE, 1, 32'h00000001, 32'hFFFFFFFD, 0);
        waitIdle();
        issue(2'b11, 32'hFFFFFFF8, 32'h00000003, 1, 32'hFFFFFFFE, 32'hFFFFFFFE, 0);
        waitIdle();
        issue(2'b11, 32'hFFFFFFF9, 32'h00000000, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
        waitIdle();
        issue(2'b01, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 0);
        waitIdle();
        issue(2'b01, 32'h00000007, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFF9, 0);
        waitIdle();
        issue(2'b10, 32'hFFFFFFFF, 32'h00000010, 1, 32'h0000000F, 32'h0FFFFFFF, 0);
        waitIdle();
        // abort together with start in IDLE: start wins.
        issue(2'b10, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1);
        waitIdle();

        // Direct write on the accept edge.
        lo_we = 1'b1; wLo = 32'h00000055;
        issue(2'b00, 32'h1, 32'h1, 1, 32'h0, 32'h1, 0);
        lo_we = 1'b0;
        check("writeOnAccept", rLo, 32'h00000055);
        waitIdle();

        // Direct write during CALC, later overwritten by the result.
        issue(2'b00, 32'd3, 32'd4, 1, 32'h0, 32'd12, 0);
        repeat (5) @(posedge clk);
        #1;
        hi_we = 1'b1; wHi = 32'h12345678;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check("writeInCalc", rHi, 32'h12345678);
        waitIdle();

        // Direct write colliding with writeback: result retained.
        issue(2'b00, 32'd2, 32'd3, 1, 32'h0, 32'd6, 0);
        repeat (W) @(posedge clk);
        #1;
        hi_we = 1'b1; lo_we = 1'b1; wHi = 32'hDEADBEEF; wLo = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0;
        waitIdle();

        // Abort mid-MULTU with preloaded registers.
        hi_we = 1'b1; lo_we = 1'b1; wHi = 32'hAAAA5555; wLo = 32'hAAAA5555;
        @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0;
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 0);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abortBusy", 32'(busy), 32'h0);
        repeat (W + 5) @(posedge clk);
        #1;
        check("abortHi", rHi, 32'hAAAA5555);
        check("abortLo", rLo, 32'hAAAA5555);

        // Asynchronous reset mid-DIVU.
        @(negedge clk);
        issue(2'b10, 32'd1000, 32'd3, 0, 32'h0, 32'h0, 0);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstHi", rHi, 32'h0);
        check("rstLo", rLo, 32'h0);
        check("rstBusy", 32'(busy), 32'h0);
        check("rstDone", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 5) @(posedge clk);
        #1;
        check("postRstBusy", 32'(busy), 32'h0);
        @(negedge clk);
        issue(2'b00, 32'h00010000, 32'h00010000, 1, 32'h00000001, 32'h00000000, 0);
        waitIdle();

        // Narrow instance: 0xFF * 0xFF, result after W+2 edges counting the accept edge.
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        q8.push_back('{32'h000000FE, 32'h00000001, cyc + 8 + 1});
        waitIdle();

        check("pendingResults", 32'(q.size() + q8.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
